pingpong_frame_reader: RTL and testbench

- Read sequencer between PINGPONG_RAM port B and find_max.
- When a bank is ready, it sweeps port-B addresses 0..DEPTH-1 and realigns each address with the RAM's delayed read data.
- It streams each address/data pair to find_max with a contiguous enable, then pulses finishb to hand the bank back.
- This replaces the ad-hoc address/enable pipeline currently built around find_max.

---
 rtl/pingpong_frame_reader.sv | 135 +++++++++++++
 tb/tb_pingpong_frame_reader.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pingpong_frame_reader.sv
// rtl/pingpong_frame_reader.sv - port-B frame sweep, read-latency realignment and bank release
module pingpong_frame_reader #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 128,
  parameter int RD_LAT = 2
) (
  input  logic              clk_in,
  input  logic              rst,
  input  logic              en,
  input  logic              readyb,
  output logic [ADDR_W-1:0] addrb,
  input  logic [DATA_W-1:0] doutb,
  output logic              finishb,
  output logic              ena_out,
  output logic [DATA_W-1:0] data_out,
  output logic [ADDR_W-1:0] addr_out,
  output logic              last_out,
  output logic              busy,
  output logic [15:0]       frame_cnt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SWEEP,
    S_DRAIN,
    S_RELEASE,
    S_HOLD
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_t state, state_nxt;
  logic   issue;
  logic   pipe_empty;

  // Tag pipeline: one stage per cycle of RAM read latency
  logic [RD_LAT-1:0]             tag_vld;
  logic [RD_LAT-1:0]             tag_last;
  logic [RD_LAT-1:0][ADDR_W-1:0] tag_addr;

  assign pipe_empty = ~|tag_vld;

  // State register
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state and per-state outputs; DRAIN waits until the final tag has
  // left the pipeline so finishb lands the cycle after last_out
  always_comb begin
    state_nxt = state;
    finishb   = 1'b0;
    busy      = 1'b1;
    issue     = 1'b0;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (en && readyb) state_nxt = S_SWEEP;
      end
      S_SWEEP: begin
        issue = 1'b1;
        if (addrb == LAST_ADDR) state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if (pipe_empty) state_nxt = S_RELEASE;
      end
      S_RELEASE: begin
        finishb   = 1'b1;
        state_nxt = S_HOLD;
      end
      S_HOLD: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Read address: counts during SWEEP, parks at the last address in DRAIN, else 0
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      addrb <= '0;
    end else if (state == S_SWEEP) begin
      if (addrb != LAST_ADDR) addrb <= addrb + 1'b1;
    end else if (state != S_DRAIN || pipe_empty) begin
      addrb <= '0;
    end
  end

  // Shift each issued address down the tag pipeline alongside the RAM latency
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      tag_vld  <= '0;
      tag_last <= '0;
      tag_addr <= '0;
    end else begin
      tag_vld[0]  <= issue;
      tag_last[0] <= issue && (addrb == LAST_ADDR);
      tag_addr[0] <= addrb;
      for (int i = 1; i < RD_LAT; i++) begin
        tag_vld[i]  <= tag_vld[i-1];
        tag_last[i] <= tag_last[i-1];
        tag_addr[i] <= tag_addr[i-1];
      end
    end
  end

  // Output stage: capture RAM data with its matching tag; hold data/addr when idle
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      ena_out  <= 1'b0;
      data_out <= '0;
      addr_out <= '0;
      last_out <= 1'b0;
    end else if (tag_vld[RD_LAT-1]) begin
      ena_out  <= 1'b1;
      data_out <= doutb;
      addr_out <= tag_addr[RD_LAT-1];
      last_out <= tag_last[RD_LAT-1];
    end else begin
      ena_out  <= 1'b0;
      last_out <= 1'b0;
    end
  end

  // Completed-frame counter, wraps silently
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst)                    frame_cnt <= '0;
    else if (state == S_RELEASE) frame_cnt <= frame_cnt + 1'b1;
  end

endmodule

// File: tb/tb_pingpong_frame_reader.sv
// tb/tb_pingpong_frame_reader.sv - model-checked bench over RD_LAT 1, 2 and 4
module tb_pingpong_frame_reader;

  localparam int ADDR_W = 7;
  localparam int DEPTH  = 128;
  localparam int N      = 3;

  logic clk_in = 1'b0;
  logic rst, en, readyb;

  logic [ADDR_W-1:0] addrb     [N];
  logic [ADDR_W-1:0] addr_out  [N];
  logic [7:0]        data_out  [N];
  logic              finishb   [N];
  logic              ena_out   [N];
  logic              last_out  [N];
  logic              busy      [N];
  logic [15:0]       frame_cnt [N];

  logic [7:0] mem [DEPTH];

  always #5 clk_in = ~clk_in;

  function automatic int lat_of(input int i);
    return (i == 0) ? 1 : ((i == 1) ? 2 : 4);
  endfunction

  for (genvar g = 0; g < N; g++) begin : g_dut
    localparam int LAT = (g == 0) ? 1 : ((g == 1) ? 2 : 4);
    logic [ADDR_W-1:0] rp [4] = '{default: '0};
    logic [7:0]        dq;

    // Synchronous RAM read port with LAT cycles of latency
    always @(posedge clk_in) begin
      rp[0] <= addrb[g];
      for (int k = 1; k < 4; k++) rp[k] <= rp[k-1];
    end
    assign dq = mem[rp[LAT-1]];

    pingpong_frame_reader #(.ADDR_W(ADDR_W), .DATA_W(8), .DEPTH(DEPTH), .RD_LAT(LAT)) u_dut (
      .clk_in    (clk_in),
      .rst       (rst),
      .en        (en),
      .readyb    (readyb),
      .addrb     (addrb[g]),
      .doutb     (dq),
      .finishb   (finishb[g]),
      .ena_out   (ena_out[g]),
      .data_out  (data_out[g]),
      .addr_out  (addr_out[g]),
      .last_out  (last_out[g]),
      .busy      (busy[g]),
      .frame_cnt (frame_cnt[g])
    );
  end

  int n_cmp = 0;
  int n_err = 0;

  // Model: cycle offset within the current frame (-1 when idle)
  int         c_m  [N];
  int         fc_m [N];
  logic [7:0] hd_m [N];
  int         ha_m [N];

  // Per-frame observations of the DUT stream
  int         since     [N];
  int         ena_cnt   [N];
  int         last_cnt  [N];
  int         first_lat [N];
  logic       bprev     [N];
  logic [7:0] mx        [N];
  int         mxa       [N];

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: actual %0d required %0d", name, act, exp);
    end
  endtask

  task automatic check_cycle();
    for (int i = 0; i < N; i++) begin
      int lat, c, ea, ed, eaddrb, cn;
      logic eena, elast, efin, ebusy;
      lat = lat_of(i);
      c   = c_m[i];
      if (rst) begin
        eaddrb = 0; eena = 0; ed = 0; ea = 0; elast = 0; efin = 0; ebusy = 0;
      end else begin
        ebusy = (c >= 0);
        if (c < 0)                eaddrb = 0;
        else if (c < DEPTH)       eaddrb = c;
        else if (c <= DEPTH + lat) eaddrb = DEPTH - 1;
        else                      eaddrb = 0;
        eena = (c >= lat + 1) && (c <= lat + DEPTH);
        if (eena) begin
          ea = c - lat - 1;
          ed = mem[ea];
          elast = (ea == DEPTH - 1);
        end else begin
          ea = ha_m[i];
          ed = hd_m[i];
          elast = 1'b0;
        end
        efin = (c == DEPTH + lat + 1);
      end
      chk($sformatf("lat%0d addrb", lat),     addrb[i],     eaddrb);
      chk($sformatf("lat%0d ena_out", lat),   ena_out[i],   eena);
      chk($sformatf("lat%0d data_out", lat),  data_out[i],  ed);
      chk($sformatf("lat%0d addr_out", lat),  addr_out[i],  ea);
      chk($sformatf("lat%0d last_out", lat),  last_out[i],  elast);
      chk($sformatf("lat%0d finishb", lat),   finishb[i],   efin);
      chk($sformatf("lat%0d busy", lat),      busy[i],      ebusy);
      chk($sformatf("lat%0d frame_cnt", lat), frame_cnt[i], rst ? 0 : fc_m[i]);

      if (!rst) begin
        if (busy[i] && !bprev[i]) begin
          since[i] = 0; ena_cnt[i] = 0; last_cnt[i] = 0; first_lat[i] = -1;
          mx[i] = 8'h00; mxa[i] = -1;
        end else begin
          since[i]++;
        end
        if (ena_out[i]) begin
          if (first_lat[i] < 0) first_lat[i] = since[i];
          ena_cnt[i]++;
          if (last_out[i]) last_cnt[i]++;
          if (data_out[i] > mx[i]) begin
            mx[i]  = data_out[i];
            mxa[i] = addr_out[i];
          end
        end
      end
      bprev[i] = rst ? 1'b0 : busy[i];

      if (rst) begin
        c_m[i] = -1; fc_m[i] = 0; hd_m[i] = 8'h00; ha_m[i] = 0;
      end else begin
        if (eena) begin
          hd_m[i] = ed[7:0];
          ha_m[i] = ea;
        end
        if (c == DEPTH + lat + 1) fc_m[i] = (fc_m[i] + 1) % 65536;
        if (c < 0) begin
          if (en && readyb) c_m[i] = 0;
        end else begin
          cn = c + 1;
          c_m[i] = (cn > DEPTH + lat + 2) ? -1 : cn;
        end
      end
    end
  endtask

  task automatic tick();
    @(negedge clk_in);
    check_cycle();
    @(posedge clk_in);
    #2;
  endtask

  task automatic run_till_idle(input int budget);
    logic any;
    any = 1'b1;
    for (int k = 0; k < budget && any; k++) begin
      tick();
      any = busy[0] | busy[1] | busy[2];
    end
    chk("idle timeout", any, 0);
  endtask

  task automatic start_one();
    en = 1'b1; readyb = 1'b1;
    tick();
    en = 1'b0; readyb = 1'b0;
    run_till_idle(400);
  endtask

  task automatic wait_fin(input int budget);
    logic seen;
    seen = 1'b0;
    for (int k = 0; k < budget && !seen; k++) begin
      tick();
      seen = finishb[1];
    end
    chk("finishb timeout", seen, 1);
    tick();
  endtask

  initial begin
    int base;
    logic hit;
    for (int i = 0; i < N; i++) begin
      c_m[i] = -1; fc_m[i] = 0; hd_m[i] = 8'h00; ha_m[i] = 0;
      since[i] = 0; ena_cnt[i] = 0; last_cnt[i] = 0; first_lat[i] = -1;
      bprev[i] = 1'b0; mx[i] = 8'h00; mxa[i] = -1;
    end
    for (int a = 0; a < DEPTH; a++) mem[a] = 8'(a);
    rst = 1'b1; en = 1'b0; readyb = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    chk("reset frame_cnt", frame_cnt[1], 0);

    // Gating: readyb without en never starts a frame
    readyb = 1'b1;
    repeat (50) tick();
    chk("gate addrb", addrb[1], 0);
    chk("gate busy", busy[1], 0);
    en = 1'b1;
    tick();
    chk("gate start", busy[1], 1);
    en = 1'b0; readyb = 1'b0;
    run_till_idle(400);

    // Ramp frame
    chk("ramp ena count", ena_cnt[1], 128);
    chk("ramp last count", last_cnt[1], 1);
    chk("ramp max data", mx[1], 127);
    chk("ramp frame_cnt", frame_cnt[1], 1);
    chk("lat1 first ena", first_lat[0], 2);
    chk("lat2 first ena", first_lat[1], 3);
    chk("lat4 first ena", first_lat[2], 5);

    // Inverted ramp across latencies
    for (int a = 0; a < DEPTH; a++) mem[a] = 8'(255 - a);
    start_one();
    chk("inv lat4 ena count", ena_cnt[2], 128);
    chk("inv lat1 first ena", first_lat[0], 2);
    chk("inv frame_cnt", frame_cnt[1], 2);

    // Single peak as find_max would see it
    for (int a = 0; a < DEPTH; a++) mem[a] = 8'h10;
    mem[37] = 8'hC8;
    start_one();
    for (int i = 0; i < N; i++) begin
      chk($sformatf("peak data lat%0d", lat_of(i)), mx[i], 8'hC8);
      chk($sformatf("peak addr lat%0d", lat_of(i)), mxa[i], 37);
    end

    // Back-to-back frames
    for (int a = 0; a < DEPTH; a++) mem[a] = 8'($urandom_range(0, 255));
    base = frame_cnt[1];
    en = 1'b1; readyb = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      wait_fin(400);
      chk($sformatf("b2b frame_cnt %0d", k), frame_cnt[1], base + k);
    end
    en = 1'b0; readyb = 1'b0;
    run_till_idle(400);

    // Reset abort mid-sweep
    for (int a = 0; a < DEPTH; a++) mem[a] = 8'(a);
    en = 1'b1; readyb = 1'b1;
    tick();
    en = 1'b0;
    hit = 1'b0;
    for (int k = 0; k < 200 && !hit; k++) begin
      if (addrb[1] == 7'd60) hit = 1'b1;
      else tick();
    end
    chk("abort reach addr 60", hit, 1);
    rst = 1'b1;
    tick();
    chk("abort addrb", addrb[1], 0);
    chk("abort finishb", finishb[1], 0);
    chk("abort frame_cnt", frame_cnt[1], 0);
    rst = 1'b0;
    tick();
    start_one();
    chk("post-abort ena count", ena_cnt[1], 128);
    chk("post-abort frame_cnt", frame_cnt[1], 1);

    // Random en/readyb/reset traffic
    for (int a = 0; a < DEPTH; a++) mem[a] = 8'($urandom_range(0, 255));
    for (int k = 0; k < 2000; k++) begin
      en     = ($urandom_range(0, 3) != 0);
      readyb = ($urandom_range(0, 2) != 0);
      rst    = ($urandom_range(0, 399) == 0);
      tick();
    end
    rst = 1'b0; en = 1'b0; readyb = 1'b0;
    run_till_idle(400);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
